// File: rtl/input_debounce_if.sv
// Bundle between the raw K0/K1 button pins and the debounce stage.
// Ports: tick, raw pins in; debounced values and edge strobes out.
interface input_debounce_if;
  logic       tick;
  logic [3:0] input_k0_raw;
  logic [3:0] input_k1_raw;
  logic [3:0] input_k0;
  logic [3:0] input_k1;
  logic [3:0] k0_falling;
  logic [3:0] k1_falling;
  logic       k0_changed;
  logic       k1_changed;

  modport master (
    output tick,
    output input_k0_raw,
    output input_k1_raw,
    input  input_k0,
    input  input_k1,
    input  k0_falling,
    input  k1_falling,
    input  k0_changed,
    input  k1_changed
  );

  modport slave (
    input  tick,
    input  input_k0_raw,
    input  input_k1_raw,
    output input_k0,
    output input_k1,
    output k0_falling,
    output k1_falling,
    output k0_changed,
    output k1_changed
  );
endinterface

// File: rtl/input_debounce.sv
// Two-flop sync plus per-bit tick-gated debounce of the K0/K1 pins.
// Ports: clk, reset (async, active-high), bus (slave side).
module input_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter logic [7:0]  IDLE_VALUE     = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  input_debounce_if.slave bus
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_TICKS - 1);

  logic [7:0] raw;
  logic [7:0] sync1_q, sync2_q;
  logic [7:0] stable_q, stable_d;
  logic [7:0] cnt_q [8];
  logic [7:0] cnt_d [8];
  logic [7:0] fall_q, fall_d;
  logic [1:0] chg_q, chg_d;
  logic [7:0] diff;

  assign raw = {bus.input_k1_raw, bus.input_k0_raw};

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (bus.tick) begin
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    // Strobes are derived from next vs current stable so they
    // rise in the very cycle the new stable value appears.
    diff   = stable_q ^ stable_d;
    fall_d = stable_q & ~stable_d;
    chg_d  = {|diff[7:4], |diff[3:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= IDLE_VALUE;
      sync2_q  <= IDLE_VALUE;
      stable_q <= IDLE_VALUE;
      for (int i = 0; i < 8; i++) cnt_q[i] <= 8'd0;
      fall_q   <= 8'd0;
      chg_q    <= 2'd0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
      chg_q    <= chg_d;
    end
  end

  assign bus.input_k0   = stable_q[3:0];
  assign bus.input_k1   = stable_q[7:4];
  assign bus.k0_falling = fall_q[3:0];
  assign bus.k1_falling = fall_q[7:4];
  assign bus.k0_changed = chg_q[0];
  assign bus.k1_changed = chg_q[1];

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a window-based reference model.
// Ports: none (top-level bench).
module tb_input_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  input_debounce_if bus ();

  input_debounce #(
    .DEBOUNCE_TICKS(N),
    .IDLE_VALUE    (8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: a stable bit flips once its last N ticked sync
  // samples all show the opposite level.
  logic [7:0] m_s1, m_s2, m_st, m_fall, new_st, dl;
  logic [1:0] m_chg;
  logic [7:0] hist [$];
  bit         all_opp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 8'hFF;
      m_s2 = 8'hFF;
      m_st = 8'hFF;
      m_fall = 8'h00;
      m_chg = 2'b00;
      hist.delete();
    end else begin
      new_st = m_st;
      if (bus.tick) begin
        hist.push_back(m_s2);
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
          for (int b = 0; b < 8; b++) begin
            all_opp = 1'b1;
            for (int k = 0; k < N; k++)
              if (hist[k][b] == m_st[b]) all_opp = 1'b0;
            if (all_opp) new_st[b] = ~m_st[b];
          end
        end
      end
      dl = m_st ^ new_st;
      m_fall = m_st & ~new_st;
      m_chg = {|dl[7:4], |dl[3:0]};
      m_st = new_st;
      m_s2 = m_s1;
      m_s1 = {bus.input_k1_raw, bus.input_k0_raw};
    end
  end

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("m_k0", {4'h0, bus.input_k0}, {4'h0, m_st[3:0]});
      chk("m_k1", {4'h0, bus.input_k1}, {4'h0, m_st[7:4]});
      chk("m_f0", {4'h0, bus.k0_falling}, {4'h0, m_fall[3:0]});
      chk("m_f1", {4'h0, bus.k1_falling}, {4'h0, m_fall[7:4]});
      chk("m_c0", {7'h0, bus.k0_changed}, {7'h0, m_chg[0]});
      chk("m_c1", {7'h0, bus.k1_changed}, {7'h0, m_chg[1]});
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(string nm, logic [3:0] k0, logic [3:0] k1,
                         logic [3:0] f0, logic [3:0] f1,
                         logic c0, logic c1);
    chk({nm, "_k0"}, {4'h0, bus.input_k0}, {4'h0, k0});
    chk({nm, "_k1"}, {4'h0, bus.input_k1}, {4'h0, k1});
    chk({nm, "_f0"}, {4'h0, bus.k0_falling}, {4'h0, f0});
    chk({nm, "_f1"}, {4'h0, bus.k1_falling}, {4'h0, f1});
    chk({nm, "_c0"}, {7'h0, bus.k0_changed}, {7'h0, c0});
    chk({nm, "_c1"}, {7'h0, bus.k1_changed}, {7'h0, c1});
  endtask

  initial begin
    bus.tick = 1'b1;
    bus.input_k0_raw = 4'hF;
    bus.input_k1_raw = 4'hF;
    #1 reset = 1'b1;
    #1 go = 1'b1;

    // 1: reset state, quiet release
    step(3);
    chk_out("rst", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(8);
    chk_out("rel", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);

    // 2: press K0[0], update after exactly 6 edges
    bus.input_k0_raw = 4'hE;
    step(5);
    chk_out("p5", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1);
    chk_out("p6", 4'hE, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
    step(1);
    chk_out("p7", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);

    // 3: 3-cycle glitch rejected, 4-cycle low accepted
    bus.input_k1_raw = 4'hB;
    step(3);
    bus.input_k1_raw = 4'hF;
    step(10);
    chk_out("g3", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    bus.input_k1_raw = 4'hB;
    step(4);
    bus.input_k1_raw = 4'hF;
    step(2);
    chk_out("g4", 4'hE, 4'hB, 4'h0, 4'h4, 1'b0, 1'b1);
    step(1);
    chk_out("g4b", 4'hE, 4'hB, 4'h0, 4'h0, 1'b0, 1'b0);
    step(10);
    chk_out("g4r", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);

    // 4: sparse ticks, count holds in between
    bus.tick = 1'b0;
    bus.input_k0_raw = 4'h0;
    step(2);
    for (int t = 1; t <= 4; t++) begin
      bus.tick = 1'b1;
      step(1);
      if (t == 3) chk_out("sp3", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
      if (t == 4) chk_out("sp4", 4'h0, 4'hF, 4'hE, 4'h0, 1'b1, 1'b0);
      bus.tick = 1'b0;
      step(2);
    end
    bus.tick = 1'b1;

    // 5: releases give changed without falling
    bus.input_k0_raw = 4'hE;
    step(8);
    chk_out("r1", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    bus.input_k0_raw = 4'hF;
    step(5);
    chk_out("r5", 4'hE, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1);
    chk_out("r6", 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);

    // 6: reset mid-count, full recount afterwards
    bus.input_k1_raw = 4'h0;
    step(8);
    chk_out("k1p", 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    bus.input_k0_raw = 4'h7;
    step(4);
    #2 reset = 1'b1;
    #1 chk_out("arst", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    bus.input_k1_raw = 4'hF;
    step(2);
    reset = 1'b0;
    step(5);
    chk_out("rc5", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1);
    chk_out("rc6", 4'h7, 4'hF, 4'h8, 4'h0, 1'b1, 1'b0);
    step(3);

    go = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Conditions the raw K0/K1 button port pins before they reach the input-lines/interrupt-factor stage.
- Synchronises each of the 8 raw pins into the core clock domain and debounces each bit independently with a tick-gated counter.
- Presents stable input_k0/input_k1 values plus per-bit falling-edge and any-change strobes to the downstream stage.
- Idle (released) level is high; a press drives a pin low.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive ticks a synchronised bit must disagree with its stable value before the stable value updates; legal range 1..255.
- IDLE_VALUE, 8'hFF, reset value of the stable outputs; bits [3:0] are K0, bits [7:4] are K1.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  debounce sample enable; one clk-cycle pulse.
- input_k0_raw  in  4  raw K0 pins, asynchronous to clk.
- input_k1_raw  in  4  raw K1 pins, asynchronous to clk.
- input_k0  out  4  debounced K0.
- input_k1  out  4  debounced K1.
- k0_falling  out  4  per-bit 1-clk pulse on a debounced K0 1->0 transition.
- k1_falling  out  4  per-bit 1-clk pulse on a debounced K1 1->0 transition.
- k0_changed  out  1  1-clk pulse when any debounced K0 bit changes.
- k1_changed  out  1  1-clk pulse when any debounced K1 bit changes.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-count.
  - Both sync stages and the stable registers load from IDLE_VALUE.
  - All counters clear to 0.
  - All strobes are 0.
  - No strobe fires on reset deassertion.
- Synchroniser: 2 flops per bit, clocked every clk and not gated by tick. sync[i] is raw[i] delayed by 2 clk edges.
- Per-bit counter, 8 bits wide, updated only in cycles where tick=1:
  - If sync[i] == stable[i]: counter <= 0.
  - Else if counter == DEBOUNCE_TICKS-1: stable[i] <= sync[i] and counter <= 0.
  - Else: counter <= counter+1.
- A bit therefore updates on the DEBOUNCE_TICKS-th consecutive tick of disagreement.
  - Any tick with agreement (a glitch) restarts the count from 0.
  - DEBOUNCE_TICKS=1 means the update happens on the first disagreeing tick.
- In cycles with tick=0, counters and stable values hold. Sync flops still advance.
- Latency, with tick high every cycle: a raw change is first visible on input_kX after 2+DEBOUNCE_TICKS clk edges.
- Strobes are registered and assert in the same cycle the stable value changes, for exactly 1 clk.
  - kX_falling[i] = 1 when stable[i] goes 1->0.
  - kX_changed = OR of any bit changing in either direction.
  - A rising transition asserts kX_changed only.
- Bits are independent. Simultaneous updates on several bits produce one kX_changed pulse and multiple falling bits in the same cycle.
- Raw toggling faster than DEBOUNCE_TICKS ticks never changes the stable value.
- No counter wrap is possible: the counter clears at DEBOUNCE_TICKS-1 ≤ 254.
- Outputs never assert X after reset. Strobes are never asserted while reset is high.

Test Plan (DEBOUNCE_TICKS=4, tick=1 every cycle unless stated):
1. Reset with raw=8'hFF -> input_k0=4'hF, input_k1=4'hF, all strobes 0; deassert reset -> no strobe pulse.
2. Drive input_k0_raw 4'hF->4'hE and hold -> input_k0=4'hE exactly 6 clk edges later; k0_falling=4'h1 and k0_changed=1 for exactly that one cycle; K1 outputs unchanged.
3. Glitch input_k1_raw[2] low for 3 cycles, then back high -> input_k1 stays 4'hF and no k1 strobe fires. Repeat with a 4-cycle low -> input_k1=4'hB, k1_falling=4'h4.
4. Tick every 3rd cycle with raw K0=4'h0 held -> input_k0 updates on the 4th tick seen after the sync delay; the count holds between ticks.
5. Release after press: raw K0 4'hE->4'hF -> input_k0=4'hF, k0_changed=1, k0_falling=0.
6. Assert reset after 2 disagreeing ticks on K0[3] -> immediate return to IDLE_VALUE. After release with raw still low, a full 4 more ticks are required before the update.
